reduce_tree_pipe: RTL



---
 rtl/reduce_tree_pipe.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/reduce_tree_pipe.sv
// Pipelined bitwise reduction tree: collapses a WIDTH-bit vector to one bit.
// Operators: 00 AND, 01 OR, 10 XOR, 11 ALT (per-level AND/XOR/OR/XOR).
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid / in_ready   input handshake
//   in_data[WIDTH]        vector to reduce
//   in_op[2]              operator select
//   in_tag[TAG_W]         sideband tag, returned with the result
//   out_valid / out_ready output handshake
//   out_data              reduction result
//   out_tag[TAG_W]        tag of the transaction in out_data
module reduce_tree_pipe #(
    parameter int WIDTH     = 16,
    parameter int REG_EVERY = 2,
    parameter int TAG_W     = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [1:0]       in_op,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_data,
    output logic [TAG_W-1:0] out_tag
);

    localparam int L = $clog2(WIDTH);

    // One tree node. ALT maps level k onto AND, XOR, OR, XOR for k mod 4 = 1, 2, 3, 0.
    function automatic logic comb_bit(
        input logic       a,
        input logic       b,
        input logic [1:0] op,
        input int         k
    );
        logic [1:0] eff;
        eff = op;
        if (op == 2'b11) begin
            case (k % 4)
                1:       eff = 2'b00;
                3:       eff = 2'b01;
                default: eff = 2'b10;
            endcase
        end
        case (eff)
            2'b00:   comb_bit = a & b;
            2'b01:   comb_bit = a | b;
            default: comb_bit = a ^ b;
        endcase
    endfunction

    // The whole pipe freezes while the output holds an unaccepted result.
    logic stall;
    assign stall    = out_valid & ~out_ready;
    assign in_ready = ~stall;

    logic [WIDTH-1:0] s0_d;
    logic [1:0]       s0_op;
    logic [TAG_W-1:0] s0_tag;
    logic             s0_v;

    // Payload loads only on a real handshake so idle-bus values never enter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s0_d   <= '0;
            s0_op  <= '0;
            s0_tag <= '0;
            s0_v   <= 1'b0;
        end else if (!stall) begin
            s0_v <= in_valid;
            if (in_valid) begin
                s0_d   <= in_data;
                s0_op  <= in_op;
                s0_tag <= in_tag;
            end
        end
    end

    // Levels 1..L-1; the last level feeds the output register below.
    for (genvar k = 1; k < L; k++) begin : g_lvl
        localparam int NI = WIDTH >> (k - 1);
        localparam int NO = NI / 2;

        logic [NI-1:0]    sd;
        logic [1:0]       so;
        logic [TAG_W-1:0] st;
        logic             sv;

        if (k == 1) begin : g_src
            assign sd = s0_d;
            assign so = s0_op;
            assign st = s0_tag;
            assign sv = s0_v;
        end else begin : g_src
            assign sd = g_lvl[k-1].p;
            assign so = g_lvl[k-1].o;
            assign st = g_lvl[k-1].t;
            assign sv = g_lvl[k-1].v;
        end

        logic [NO-1:0] c;

        always_comb begin
            c = '0;
            for (int i = 0; i < NO; i++) begin
                c[i] = comb_bit(sd[i+NO], sd[i], so, k);
            end
        end

        logic [NO-1:0]    p;
        logic [1:0]       o;
        logic [TAG_W-1:0] t;
        logic             v;

        if (k % REG_EVERY == 0) begin : g_reg
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    p <= '0;
                    o <= '0;
                    t <= '0;
                    v <= 1'b0;
                end else if (!stall) begin
                    v <= sv;
                    if (sv) begin
                        p <= c;
                        o <= so;
                        t <= st;
                    end
                end
            end
        end else begin : g_wire
            assign p = c;
            assign o = so;
            assign t = st;
            assign v = sv;
        end
    end

    logic [1:0]       fd;
    logic [1:0]       fo;
    logic [TAG_W-1:0] ft;
    logic             fv;

    if (L == 1) begin : g_fin
        assign fd = s0_d;
        assign fo = s0_op;
        assign ft = s0_tag;
        assign fv = s0_v;
    end else begin : g_fin
        assign fd = g_lvl[L-1].p;
        assign fo = g_lvl[L-1].o;
        assign ft = g_lvl[L-1].t;
        assign fv = g_lvl[L-1].v;
    end

    logic res;
    assign res = comb_bit(fd[1], fd[0], fo, L);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data  <= 1'b0;
            out_tag   <= '0;
            out_valid <= 1'b0;
        end else if (!stall) begin
            out_valid <= fv;
            if (fv) begin
                out_data <= res;
                out_tag  <= ft;
            end
        end
    end

endmodule
